// File: rtl/life_writeback_pkt.sv
// life_writeback_pkt: packs NUM_PE-cell next-state strips into WORD_SIZE-bit words and writes one frame with valid/ready on both sides; define WB_POPCOUNT_EN to add pop_cnt_out
module life_writeback_pkt #(
    parameter int WORD_SIZE    = 32,
    parameter int NUM_PE       = 4,
    parameter int LOG_MAX_ADDR = 13,
    parameter int BASE_ADDR    = 0,
    parameter int NUM_WORDS    = 2048
) (
`ifdef WB_POPCOUNT_EN
    output logic [LOG_MAX_ADDR+$clog2(WORD_SIZE):0] pop_cnt_out,
`endif
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    start_in,
    input  logic                    valid_in,
    input  logic [NUM_PE-1:0]       state_in,
    input  logic                    last_in,
    output logic                    ready_out,
    output logic                    wr_en_out,
    input  logic                    wr_ready_in,
    output logic [LOG_MAX_ADDR-1:0] addr_w_out,
    output logic [WORD_SIZE-1:0]    data_w_out,
    output logic                    done_out,
    output logic [LOG_MAX_ADDR:0]   word_cnt_out,
    output logic                    overrun_out
);
    localparam int K = WORD_SIZE / NUM_PE;
    localparam int LCW = $clog2(K + 1);
    localparam int SW = $clog2(WORD_SIZE + 1);
    localparam logic [LCW-1:0] K_L = LCW'(K);
    localparam logic [LCW-1:0] KM1 = LCW'(K - 1);
    localparam logic [LOG_MAX_ADDR-1:0] A_BASE = LOG_MAX_ADDR'(BASE_ADDR);
    localparam logic [LOG_MAX_ADDR-1:0] A_LAST = LOG_MAX_ADDR'(BASE_ADDR + NUM_WORDS - 1);

    typedef enum logic [2:0] {IDLE, FILL, FLUSH, DRAIN, DONE} state_t;

    state_t state, state_nx;
    logic [WORD_SIZE-1:0] sh, sh_acc, word;
    logic [LCW-1:0] lc, lc_nx;
    logic [SW-1:0] pad_sh;
    logic cap, accept, load, wr_done;

    // handshake, word selection and next-state; a strip completing a word goes straight to the output register
    always_comb begin
        cap = !wr_en_out || wr_ready_in;
        wr_done = wr_en_out && wr_ready_in;
        ready_out = !start_in && state == FILL && (lc != K_L || cap);
        accept = valid_in && ready_out;
        sh_acc = (sh << NUM_PE) | WORD_SIZE'(state_in);
        pad_sh = SW'(WORD_SIZE - NUM_PE * int'(lc));
        word = state == FLUSH ? sh << pad_sh : lc == K_L ? sh : sh_acc;
        load = !start_in && cap && (state == FLUSH || (state == FILL && (lc == K_L || (lc == KM1 && accept))));
        lc_nx = load ? ((state == FILL && lc == K_L && accept) ? LCW'(1) : '0) : accept ? lc + LCW'(1) : lc;
        state_nx = start_in ? FILL :
                   (state == FILL && accept && last_in) ? (lc_nx != '0 ? FLUSH : DRAIN) :
                   (state == FLUSH && load) ? DRAIN :
                   (state == DRAIN && cap) ? DONE : state;
        done_out = state == IDLE || state == DONE;
    end

    // FSM state register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else state <= state_nx;
    end

    // strip packing, output word register, address/count and sticky overrun
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sh <= '0;
            lc <= '0;
            wr_en_out <= 1'b0;
            data_w_out <= '0;
            addr_w_out <= A_BASE;
            word_cnt_out <= '0;
            overrun_out <= 1'b0;
        end else if (start_in) begin
            sh <= '0;
            lc <= '0;
            wr_en_out <= 1'b0;
            data_w_out <= '0;
            addr_w_out <= A_BASE;
            word_cnt_out <= '0;
            overrun_out <= 1'b0;
        end else begin
            if (accept) sh <= sh_acc;
            lc <= lc_nx;
            if (load) begin
                wr_en_out <= 1'b1;
                data_w_out <= word;
            end else if (wr_done) begin
                wr_en_out <= 1'b0;
            end
            if (wr_done) begin
                word_cnt_out <= word_cnt_out + (LOG_MAX_ADDR+1)'(1);
                addr_w_out <= addr_w_out == A_LAST ? A_BASE : addr_w_out + LOG_MAX_ADDR'(1);
                if (addr_w_out == A_LAST && state == FILL) overrun_out <= 1'b1;
            end
        end
    end

`ifdef WB_POPCOUNT_EN
    localparam int PW = LOG_MAX_ADDR + $clog2(WORD_SIZE) + 1;
    logic [PW-1:0] pop_add;

    // live cells in the presented strip
    always_comb begin
        pop_add = '0;
        for (int i = 0; i < NUM_PE; i++) pop_add = pop_add + PW'(state_in[i]);
    end

    // live cells accepted in the current frame
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) pop_cnt_out <= '0;
        else if (start_in) pop_cnt_out <= '0;
        else if (accept) pop_cnt_out <= pop_cnt_out + pop_add;
    end
`endif
endmodule

// File: tb/tb_life_writeback_pkt.sv
// tb_life_writeback_pkt: word-level model and directed frames against a default instance and a small wrapping instance
module tb_life_writeback_pkt;
    localparam int K = 8;

    logic clk_in = 1'b0, rst_n_in = 1'b0, start_in = 1'b0, valid_in = 1'b0, last_in = 1'b0, wr_ready_in = 1'b1;
    logic [3:0] state_in = '0;
    logic ready[2], wr_en[2], done[2], ovr[2];
    logic [12:0] addr[2];
    logic [31:0] data[2];
    logic [13:0] cnt[2];
`ifdef WB_POPCOUNT_EN
    logic [18:0] pop[2];
`endif
    int checks = 0, errors = 0;

    always #5 clk_in = ~clk_in;

    life_writeback_pkt u0 (
`ifdef WB_POPCOUNT_EN
        .pop_cnt_out(pop[0]),
`endif
        .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in), .valid_in(valid_in),
        .state_in(state_in), .last_in(last_in), .ready_out(ready[0]), .wr_en_out(wr_en[0]),
        .wr_ready_in(wr_ready_in), .addr_w_out(addr[0]), .data_w_out(data[0]), .done_out(done[0]),
        .word_cnt_out(cnt[0]), .overrun_out(ovr[0])
    );

    life_writeback_pkt #(.BASE_ADDR(4), .NUM_WORDS(2)) u1 (
`ifdef WB_POPCOUNT_EN
        .pop_cnt_out(pop[1]),
`endif
        .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in), .valid_in(valid_in),
        .state_in(state_in), .last_in(last_in), .ready_out(ready[1]), .wr_en_out(wr_en[1]),
        .wr_ready_in(wr_ready_in), .addr_w_out(addr[1]), .data_w_out(data[1]), .done_out(done[1]),
        .word_cnt_out(cnt[1]), .overrun_out(ovr[1])
    );

    logic [31:0] exp_w[$];
    logic [31:0] acc = '0;
    int n = 0, pop_m = 0, acc_n = 0;
    int rd[2] = '{0, 0}, cnt_m[2] = '{0, 0}, base_m[2] = '{0, 4}, nw_m[2] = '{2048, 2};
    bit last_seen = 1'b0;
    bit ovr_m[2] = '{1'b0, 1'b0}, done_m[2] = '{1'b1, 1'b1}, stall_p[2] = '{1'b0, 1'b0};
    logic [31:0] data_p[2];
    logic [12:0] addr_p[2];
    logic [31:0] log_d[2][64];
    logic [12:0] log_a[2][64];
    int log_n[2] = '{0, 0};

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear(input bit from_reset);
        exp_w.delete();
        acc = '0;
        n = 0;
        pop_m = 0;
        last_seen = 1'b0;
        for (int c = 0; c < 2; c++) begin
            rd[c] = 0;
            cnt_m[c] = 0;
            ovr_m[c] = 1'b0;
            done_m[c] = from_reset;
            stall_p[c] = 1'b0;
        end
    endtask

    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            model_clear(1'b1);
        end else begin
            for (int c = 0; c < 2; c++) begin
                check($sformatf("word_cnt%0d", c), 64'(cnt[c]), 64'(cnt_m[c]));
                check($sformatf("overrun%0d", c), 64'(ovr[c]), 64'(ovr_m[c]));
                check($sformatf("done%0d", c), 64'(done[c]), 64'(done_m[c]));
                if (stall_p[c]) begin
                    check($sformatf("stall_wr_en%0d", c), 64'(wr_en[c]), 64'd1);
                    check($sformatf("stall_addr%0d", c), 64'(addr[c]), 64'(addr_p[c]));
                    check($sformatf("stall_data%0d", c), 64'(data[c]), 64'(data_p[c]));
                end
            end
            if (start_in) begin
                model_clear(1'b0);
            end else begin
                for (int c = 0; c < 2; c++) begin
                    if (wr_en[c] && wr_ready_in) begin
                        if (rd[c] < exp_w.size()) begin
                            check($sformatf("wr_data%0d", c), 64'(data[c]), 64'(exp_w[rd[c]]));
                            check($sformatf("wr_addr%0d", c), 64'(addr[c]), 64'(base_m[c] + cnt_m[c] % nw_m[c]));
                            log_d[c][log_n[c] % 64] = data[c];
                            log_a[c][log_n[c] % 64] = addr[c];
                            log_n[c]++;
                            rd[c]++;
                            cnt_m[c]++;
                            if (cnt_m[c] % nw_m[c] == 0 && !last_seen) ovr_m[c] = 1'b1;
                        end else begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_write%0d got data %0h expected no write", c, data[c]);
                        end
                    end
                end
                if (valid_in && ready[0]) begin
                    acc = (acc << 4) | 32'(state_in);
                    n++;
                    acc_n++;
                    pop_m += $countones(state_in);
                    if (n == K) begin
                        exp_w.push_back(acc);
                        acc = '0;
                        n = 0;
                    end
                    if (last_in) begin
                        if (n > 0) exp_w.push_back(acc << (32 - 4 * n));
                        last_seen = 1'b1;
                    end
                end
                for (int c = 0; c < 2; c++)
                    if (last_seen && rd[c] == exp_w.size()) done_m[c] = 1'b1;
            end
            for (int c = 0; c < 2; c++) begin
                stall_p[c] = wr_en[c] && !wr_ready_in && !start_in;
                data_p[c] = data[c];
                addr_p[c] = addr[c];
            end
        end
    end

    task automatic chk_reset(input string tag);
        for (int c = 0; c < 2; c++) begin
            check($sformatf("%s_ready%0d", tag, c), 64'(ready[c]), 64'd0);
            check($sformatf("%s_wr_en%0d", tag, c), 64'(wr_en[c]), 64'd0);
            check($sformatf("%s_addr%0d", tag, c), 64'(addr[c]), 64'(base_m[c]));
            check($sformatf("%s_data%0d", tag, c), 64'(data[c]), 64'd0);
            check($sformatf("%s_done%0d", tag, c), 64'(done[c]), 64'd1);
            check($sformatf("%s_cnt%0d", tag, c), 64'(cnt[c]), 64'd0);
            check($sformatf("%s_ovr%0d", tag, c), 64'(ovr[c]), 64'd0);
        end
    endtask

    task automatic pulse_start();
        start_in = 1'b1;
        @(posedge clk_in);
        #1;
        start_in = 1'b0;
    endtask

    task automatic send(input logic [3:0] s, input logic l);
        int t = 0;
        valid_in = 1'b1;
        state_in = s;
        last_in = l;
        @(negedge clk_in);
        while (!ready[0] && t < 200) begin
            @(negedge clk_in);
            t++;
        end
        checks++;
        if (t >= 200) begin
            errors++;
            $display("FAIL send_timeout got ready 0 expected 1");
        end
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        last_in = 1'b0;
    endtask

    task automatic stream(input int num, input logic [3:0] v, input bit inc, input bit lst);
        for (int i = 0; i < num; i++) send(inc ? 4'(i) : v, lst && i == num - 1);
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        @(negedge clk_in);
        while (!(done[0] && done[1]) && t < 300) begin
            @(negedge clk_in);
            t++;
        end
        checks++;
        if (t >= 300) begin
            errors++;
            $display("FAIL %s_done_timeout got done 0 expected 1", nm);
        end
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        int s0, s1, a0;
        repeat (2) @(posedge clk_in);
        #1;
        chk_reset("rst");
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;

        s0 = log_n[0]; s1 = log_n[1];
        pulse_start();
        stream(16, 4'hA, 1'b0, 1'b1);
        wait_done("full");
        check("full_nwr", 64'(log_n[0] - s0), 64'd2);
        check("full_d0", 64'(log_d[0][s0 % 64]), 64'hAAAA_AAAA);
        check("full_a0", 64'(log_a[0][s0 % 64]), 64'd0);
        check("full_d1", 64'(log_d[0][(s0 + 1) % 64]), 64'hAAAA_AAAA);
        check("full_a1", 64'(log_a[0][(s0 + 1) % 64]), 64'd1);
        check("full_wrap_a1", 64'(log_a[1][(s1 + 1) % 64]), 64'd5);
        check("full_cnt", 64'(cnt[0]), 64'd2);
        check("full_ovr", 64'(ovr[0]), 64'd0);

        s0 = log_n[0];
        pulse_start();
        send(4'hF, 1'b0);
        send(4'h0, 1'b0);
        send(4'h1, 1'b1);
        wait_done("flush");
        check("flush_nwr", 64'(log_n[0] - s0), 64'd1);
        check("flush_d", 64'(log_d[0][s0 % 64]), 64'hF010_0000);
        check("flush_a", 64'(log_a[0][s0 % 64]), 64'd0);
        check("flush_cnt", 64'(cnt[0]), 64'd1);

        s0 = log_n[0];
        wr_ready_in = 1'b0;
        pulse_start();
        a0 = acc_n;
        fork
            stream(24, 4'h0, 1'b1, 1'b1);
            begin
                repeat (20) @(posedge clk_in);
                #1;
                check("bp_accepts", 64'(acc_n - a0), 64'd16);
                check("bp_ready", 64'(ready[0]), 64'd0);
                wr_ready_in = 1'b1;
            end
        join
        wait_done("bp");
        check("bp_nwr", 64'(log_n[0] - s0), 64'd3);
        check("bp_d0", 64'(log_d[0][s0 % 64]), 64'h0123_4567);
        check("bp_d1", 64'(log_d[0][(s0 + 1) % 64]), 64'h89AB_CDEF);
        check("bp_cnt", 64'(cnt[0]), 64'd3);

        s1 = log_n[1];
        pulse_start();
        stream(24, 4'hC, 1'b0, 1'b1);
        wait_done("wrap");
        check("wrap_a0", 64'(log_a[1][s1 % 64]), 64'd4);
        check("wrap_a1", 64'(log_a[1][(s1 + 1) % 64]), 64'd5);
        check("wrap_a2", 64'(log_a[1][(s1 + 2) % 64]), 64'd4);
        check("wrap_cnt", 64'(cnt[1]), 64'd3);
        check("wrap_ovr1", 64'(ovr[1]), 64'd1);
        check("wrap_ovr0", 64'(ovr[0]), 64'd0);
        repeat (3) @(posedge clk_in);
        #1;
        check("wrap_ovr_hold", 64'(ovr[1]), 64'd1);

        s0 = log_n[0]; s1 = log_n[1];
        pulse_start();
        stream(5, 4'h3, 1'b0, 1'b0);
        pulse_start();
        check("abort_ovr_clr", 64'(ovr[1]), 64'd0);
        stream(8, 4'h5, 1'b0, 1'b1);
        wait_done("abort");
        check("abort_nwr", 64'(log_n[0] - s0), 64'd1);
        check("abort_d", 64'(log_d[0][s0 % 64]), 64'h5555_5555);
        check("abort_a0", 64'(log_a[0][s0 % 64]), 64'd0);
        check("abort_a1", 64'(log_a[1][s1 % 64]), 64'd4);

        pulse_start();
        wr_ready_in = 1'b0;
        stream(8, 4'h9, 1'b0, 1'b0);
        check("mid_wr_en", 64'(wr_en[0]), 64'd1);
        rst_n_in = 1'b0;
        #1;
        chk_reset("midrst");
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        wr_ready_in = 1'b1;
        @(posedge clk_in);
        #1;

`ifdef WB_POPCOUNT_EN
        pulse_start();
        stream(16, 4'h7, 1'b0, 1'b1);
        wait_done("pop");
        check("pop_lit", 64'(pop[0]), 64'd48);
        check("pop_model", 64'(pop[1]), 64'(pop_m));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
